// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: FSM state encoding, board geometry and the
// eight winning line masks (bit i of a mask = cell i, cells numbered row-major).
package ttt_pkg;

   localparam int NUM_CELLS = 9;
   localparam int NUM_LINES = 8;

   typedef enum logic [2:0] {
      ESPERA_J1  = 3'd0,
      VALIDA_J1  = 3'd1,
      GANA_J1    = 3'd2,
      ESPERA_J2  = 3'd3,
      VALIDA_J2  = 3'd4,
      GANA_J2    = 3'd5,
      FIN_GANA   = 3'd6,
      FIN_EMPATE = 3'd7
   } estado_t;

   // rows 012/345/678, columns 036/147/258, diagonals 048/246
   localparam logic [NUM_LINES-1:0][NUM_CELLS-1:0] LINE_MASKS = {
      9'h054, 9'h111, 9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007
   };

   // Lowest-index free cell; returns 9 (an invalid cell) when the board is full
   // so the caller's validity check rejects it naturally.
   function automatic logic [3:0] lowest_free(input logic [NUM_CELLS-1:0] occ);
      logic [3:0] idx;
      idx = 4'd9;
      for (int i = NUM_CELLS - 1; i >= 0; i--) begin
         if (!occ[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/linea_ganadora.sv
// Combinational win detector for one player's board.
//   tablero_i : 9-bit occupancy board, bit i = cell i
//   gana_o    : 1 when the board fully covers any of the eight lines
module linea_ganadora
   import ttt_pkg::*;
(
   input  logic [NUM_CELLS-1:0] tablero_i,
   output logic                 gana_o
);

   always_comb begin
      gana_o = 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
         if ((tablero_i & LINE_MASKS[i]) == LINE_MASKS[i]) gana_o = 1'b1;
      end
   end

endmodule

// File: rtl/control_ttt.sv
// Two-player tic-tac-toe controller with per-move idle timeout.
//   clk, rst (sync, active-low), D (confirm pulse), pos (cell 0..8), nuevo (new game)
//   estado (FSM code), j1/j2 (boards), turno, ganador, empate,
//   jugada_invalida (one-cycle reject pulse), movimientos (marks placed)
//
// state      | meaning
// ESPERA_J1  | waiting for player 1 confirm or timeout
// VALIDA_J1  | checking player 1 pending cell, placing mark
// GANA_J1    | checking player 1 lines / draw
// ESPERA_J2  | waiting for player 2 confirm or timeout
// VALIDA_J2  | checking player 2 pending cell, placing mark
// GANA_J2    | checking player 2 lines / draw
// FIN_GANA   | game won, results held until nuevo
// FIN_EMPATE | game drawn, results held until nuevo
module control_ttt
   import ttt_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 750000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       D,
   input  logic [3:0] pos,
   input  logic       nuevo,
   output logic [2:0] estado,
   output logic [8:0] j1,
   output logic [8:0] j2,
   output logic       turno,
   output logic [1:0] ganador,
   output logic       empate,
   output logic       jugada_invalida,
   output logic [3:0] movimientos
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   estado_t         estado_q;
   logic [8:0]      j1_q, j2_q;
   logic [3:0]      pend_q, movs_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      gan_q;
   logic            emp_q, inv_q, turno_q;

   logic            gana1, gana2, timeout, libre;
   logic [15:0]     occ_ext;
   logic [8:0]      celda;

   linea_ganadora u_linea_j1 (.tablero_i(j1_q), .gana_o(gana1));
   linea_ganadora u_linea_j2 (.tablero_i(j2_q), .gana_o(gana2));

   // Cells 9..15 read as permanently occupied, so one lookup rejects both
   // out-of-range and already-taken cells.
   assign occ_ext = {7'h7F, j1_q | j2_q};
   assign libre   = ~occ_ext[pend_q];
   assign celda   = 9'(1) << pend_q;
   assign timeout = (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         estado_q <= ESPERA_J1;
         j1_q     <= '0;
         j2_q     <= '0;
         pend_q   <= '0;
         movs_q   <= '0;
         cnt_q    <= '0;
         gan_q    <= '0;
         emp_q    <= 1'b0;
         inv_q    <= 1'b0;
         turno_q  <= 1'b0;
      end else if (nuevo) begin
         estado_q <= ESPERA_J1;
         j1_q     <= '0;
         j2_q     <= '0;
         pend_q   <= '0;
         movs_q   <= '0;
         cnt_q    <= '0;
         gan_q    <= '0;
         emp_q    <= 1'b0;
         inv_q    <= 1'b0;
         turno_q  <= 1'b0;
      end else begin
         inv_q <= 1'b0;
         case (estado_q)
            ESPERA_J1, ESPERA_J2: begin
               if (D || timeout) begin
                  pend_q   <= D ? pos : lowest_free(j1_q | j2_q);
                  cnt_q    <= '0;
                  estado_q <= (estado_q == ESPERA_J1) ? VALIDA_J1 : VALIDA_J2;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            VALIDA_J1, VALIDA_J2: begin
               cnt_q <= '0;
               if (libre) begin
                  if (estado_q == VALIDA_J1) j1_q <= j1_q | celda;
                  else                       j2_q <= j2_q | celda;
                  movs_q   <= movs_q + 4'd1;
                  estado_q <= (estado_q == VALIDA_J1) ? GANA_J1 : GANA_J2;
               end else begin
                  inv_q    <= 1'b1;
                  estado_q <= (estado_q == VALIDA_J1) ? ESPERA_J1 : ESPERA_J2;
               end
            end
            GANA_J1: begin
               cnt_q <= '0;
               if (gana1) begin
                  gan_q    <= 2'd1;
                  estado_q <= FIN_GANA;
               end else if (movs_q == 4'(NUM_CELLS)) begin
                  emp_q    <= 1'b1;
                  estado_q <= FIN_EMPATE;
               end else begin
                  turno_q  <= 1'b1;
                  estado_q <= ESPERA_J2;
               end
            end
            GANA_J2: begin
               cnt_q <= '0;
               if (gana2) begin
                  gan_q    <= 2'd2;
                  estado_q <= FIN_GANA;
               end else if (movs_q == 4'(NUM_CELLS)) begin
                  emp_q    <= 1'b1;
                  estado_q <= FIN_EMPATE;
               end else begin
                  turno_q  <= 1'b0;
                  estado_q <= ESPERA_J1;
               end
            end
            default: ;  // FIN_GANA / FIN_EMPATE hold everything
         endcase
      end
   end

   assign estado          = estado_q;
   assign j1              = j1_q;
   assign j2              = j2_q;
   assign turno           = turno_q;
   assign ganador         = gan_q;
   assign empate          = emp_q;
   assign jugada_invalida = inv_q;
   assign movimientos     = movs_q;

endmodule

// File: tb/tb_control_ttt.sv
module tb_control_ttt;

   logic       clk = 1'b0;
   logic       rst, D, nuevo;
   logic [3:0] pos;
   logic [2:0] estado;
   logic [8:0] j1, j2;
   logic       turno, empate, jugada_invalida;
   logic [1:0] ganador;
   logic [3:0] movimientos;

   always #5 clk = ~clk;

   control_ttt #(.TIMEOUT_CYCLES(20)) dut (
      .clk(clk), .rst(rst), .D(D), .pos(pos), .nuevo(nuevo),
      .estado(estado), .j1(j1), .j2(j2), .turno(turno), .ganador(ganador),
      .empate(empate), .jugada_invalida(jugada_invalida), .movimientos(movimientos)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // invalid-pulse monitor: counts pulses and any pulse wider than one cycle
   int   inv_cnt = 0;
   int   inv_wide = 0;
   logic inv_prev = 1'b0;
   always @(negedge clk) begin
      if (jugada_invalida === 1'b1) begin
         inv_cnt++;
         if (inv_prev) inv_wide++;
      end
      inv_prev = (jugada_invalida === 1'b1);
   end

   // reference game model
   logic [8:0] m_j1, m_j2;
   logic [3:0] m_movs;
   logic [1:0] m_gan;
   logic       m_emp, m_turn;
   logic [2:0] m_est;
   int         m_inv = 0;

   typedef struct {
      string      tag;
      logic [8:0] j1, j2;
      logic [3:0] movs;
      logic [1:0] gan;
      logic       emp, turno;
      logic [2:0] est;
      int         inv;
   } exp_t;
   exp_t sb[$];

   function automatic logic model_win(input logic [8:0] b);
      logic [8:0] ln [8];
      logic       w;
      ln = '{9'b000000111, 9'b000111000, 9'b111000000, 9'b001001001,
             9'b010010010, 9'b100100100, 9'b100010001, 9'b001010100};
      w = 1'b0;
      foreach (ln[i]) if ((b & ln[i]) == ln[i]) w = 1'b1;
      return w;
   endfunction

   task automatic model_clear();
      m_j1 = '0; m_j2 = '0; m_movs = '0; m_gan = '0;
      m_emp = 1'b0; m_turn = 1'b0; m_est = 3'd0;
   endtask

   task automatic model_move(input logic [3:0] p, input string tag);
      logic [8:0] occ, bit_p, b;
      exp_t e;
      occ = m_j1 | m_j2;
      bit_p = 9'd1 << p;
      if (m_est != 3'd6 && m_est != 3'd7) begin
         if (p < 4'd9 && (occ & bit_p) == 9'd0) begin
            if (m_turn) m_j2 = m_j2 | bit_p; else m_j1 = m_j1 | bit_p;
            m_movs = m_movs + 4'd1;
            b = m_turn ? m_j2 : m_j1;
            if (model_win(b)) begin
               m_gan = m_turn ? 2'd2 : 2'd1;
               m_est = 3'd6;
            end else if (m_movs == 4'd9) begin
               m_emp = 1'b1;
               m_est = 3'd7;
            end else begin
               m_turn = ~m_turn;
               m_est = m_turn ? 3'd3 : 3'd0;
            end
         end else begin
            m_inv++;
         end
      end
      e.tag = tag; e.j1 = m_j1; e.j2 = m_j2; e.movs = m_movs; e.gan = m_gan;
      e.emp = m_emp; e.turno = m_turn; e.est = m_est; e.inv = m_inv;
      sb.push_back(e);
   endtask

   task automatic compare_next();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({e.tag, ".estado"}, 32'(estado), 32'(e.est));
         chk({e.tag, ".j1"}, 32'(j1), 32'(e.j1));
         chk({e.tag, ".j2"}, 32'(j2), 32'(e.j2));
         chk({e.tag, ".movs"}, 32'(movimientos), 32'(e.movs));
         chk({e.tag, ".ganador"}, 32'(ganador), 32'(e.gan));
         chk({e.tag, ".empate"}, 32'(empate), 32'(e.emp));
         chk({e.tag, ".turno"}, 32'(turno), 32'(e.turno));
         chk({e.tag, ".inv"}, 32'(inv_cnt), 32'(e.inv));
      end
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, ".estado"}, 32'(estado), 32'd0);
      chk({tag, ".j1"}, 32'(j1), 32'd0);
      chk({tag, ".j2"}, 32'(j2), 32'd0);
      chk({tag, ".movs"}, 32'(movimientos), 32'd0);
      chk({tag, ".ganador"}, 32'(ganador), 32'd0);
      chk({tag, ".empate"}, 32'(empate), 32'd0);
      chk({tag, ".inv"}, 32'(jugada_invalida), 32'd0);
      chk({tag, ".turno"}, 32'(turno), 32'd0);
   endtask

   // called at a negedge with the DUT settled in a wait/final state
   task automatic play(input logic [3:0] p, input int idle, input string tag);
      repeat (idle) @(negedge clk);
      model_move(p, tag);
      pos = p; D = 1'b1;
      @(negedge clk);
      D = 1'b0;
      repeat (2) @(negedge clk);
      compare_next();
   endtask

   task automatic play_timeout(input string tag);
      logic [3:0] p;
      logic [2:0] wait_est;
      logic [8:0] j1_0, j2_0;
      p = 4'd9;
      for (int i = 8; i >= 0; i--) if (((m_j1 | m_j2) & (9'd1 << i)) == 9'd0) p = 4'(i);
      wait_est = m_est;
      j1_0 = m_j1; j2_0 = m_j2;
      model_move(p, tag);
      repeat (19) @(negedge clk);
      chk({tag, ".still_wait"}, 32'(estado), 32'(wait_est));
      chk({tag, ".j1_early"}, 32'(j1), 32'(j1_0));
      chk({tag, ".j2_early"}, 32'(j2), 32'(j2_0));
      @(negedge clk);
      chk({tag, ".valida"}, 32'(estado), 32'(wait_est + 3'd1));
      repeat (2) @(negedge clk);
      compare_next();
   endtask

   task automatic do_nuevo(input string tag);
      nuevo = 1'b1;
      @(negedge clk);
      nuevo = 1'b0;
      model_clear();
      check_cleared(tag);
   endtask

   initial begin
      rst = 1'b0; D = 1'b0; nuevo = 1'b0; pos = 4'd0;
      model_clear();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      check_cleared("reset");

      // first move: state walk 0 -> 1 -> 2 -> 3
      model_move(4'd4, "j1_pos4");
      pos = 4'd4; D = 1'b1;
      @(negedge clk);
      D = 1'b0;
      chk("walk.valida", 32'(estado), 32'd1);
      @(negedge clk);
      chk("walk.gana", 32'(estado), 32'd2);
      @(negedge clk);
      compare_next();

      // rejections: occupied cell, out-of-range cell
      play(4'd4, 0, "j2_dup4");
      play(4'd12, 0, "j2_pos12");
      play(4'd0, 0, "j2_pos0");
      play_timeout("j1_timeout");

      // nuevo while in VALIDA_J2 together with D
      pos = 4'd5; D = 1'b1;
      @(negedge clk);
      chk("nuevo.in_valida", 32'(estado), 32'd4);
      nuevo = 1'b1;
      @(negedge clk);
      nuevo = 1'b0; D = 1'b0;
      model_clear();
      check_cleared("nuevo_valida");

      // timeout auto-move for J2, then D arriving on the timeout cycle
      play(4'd0, 0, "t_j1_0");
      play_timeout("j2_timeout");
      do_nuevo("nuevo2");
      play(4'd0, 0, "d_j1_0");
      play(4'd8, 19, "d_wins_timeout");

      // player 1 wins on the top row; later D ignored
      do_nuevo("nuevo3");
      play(4'd0, 0, "w1");
      play(4'd3, 0, "w2");
      play(4'd1, 0, "w3");
      play(4'd4, 0, "w4");
      play(4'd2, 0, "w5_win");
      play(4'd8, 0, "w_ignored");

      // full-board draw
      do_nuevo("nuevo4");
      begin
         logic [3:0] seq [9];
         seq = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
         foreach (seq[i]) play(seq[i], 0, $sformatf("draw%0d", i));
      end
      play(4'd0, 0, "draw_ignored");

      // reset in the middle of a move
      do_nuevo("nuevo5");
      play(4'd2, 0, "r1");
      play(4'd6, 0, "r2");
      pos = 4'd5; D = 1'b1;
      @(negedge clk);
      D = 1'b0; rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_clear();
      check_cleared("rst_mid");
      repeat (2) @(negedge clk);
      check_cleared("rst_mid_hold");
      play(4'd7, 0, "after_rst");

      chk("inv_width", 32'(inv_wide), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/control_ttt.md
CONTROL_TTT -- requirements
Module: control_ttt

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 750000000, meaning cycles a player may idle in a wait state before an automatic move.
REQ-002 SHALL have ports:
  clk  in  1  single system clock, all logic on rising edge
  rst  in  1  reset, synchronous, active-low
  D  in  1  one-cycle confirm pulse, debounced upstream
  pos  in  4  selected cell, 0..8 valid, 9..15 invalid
  nuevo  in  1  one-cycle new-game pulse
  estado  out  3  current FSM state code
  j1  out  9  player-1 occupancy board, bit i = cell i
  j2  out  9  player-2 occupancy board
  turno  out  1  0 = player 1 to move, 1 = player 2
  ganador  out  2  0 none, 1 player 1, 2 player 2
  empate  out  1  draw flag
  jugada_invalida  out  1  one-cycle pulse on rejected move
  movimientos  out  4  count of placed marks, 0..9

Function
REQ-003 SHALL implement states, encoded as estado: ESPERA_J1=0, VALIDA_J1=1, GANA_J1=2, ESPERA_J2=3, VALIDA_J2=4, GANA_J2=5, FIN_GANA=6, FIN_EMPATE=7.
REQ-004 ESPERA_Jx: on D, SHALL latch pos into pending register and go VALIDA_Jx next cycle; timeout counter increments every cycle otherwise.
REQ-005 ESPERA_Jx: when counter reaches TIMEOUT_CYCLES-1 with no D, SHALL latch lowest-index cell free in (j1|j2) as pending and go VALIDA_Jx.
REQ-006 D and timeout in same cycle: D SHALL win.
REQ-007 VALIDA_Jx: if pending < 9 and cell free in (j1|j2), SHALL set that bit in player board, increment movimientos, go GANA_Jx; else SHALL pulse jugada_invalida one cycle, return ESPERA_Jx, clear counter.
REQ-008 GANA_Jx: if player board holds any of 8 lines {012,345,678,036,147,258,048,246}, SHALL go FIN_GANA with ganador=x; else if movimientos==9, SHALL go FIN_EMPATE with empate=1; else SHALL go ESPERA of other player with counter cleared.
REQ-009 Win check SHALL take precedence over draw when ninth move completes a line.
REQ-010 FIN_GANA/FIN_EMPATE SHALL hold boards, ganador, empate until nuevo or reset.
REQ-011 nuevo in any state SHALL, next cycle, clear j1, j2, movimientos, counter, ganador, empate and enter ESPERA_J1; nuevo has priority over D and timeout.
REQ-012 D outside ESPERA states SHALL be ignored; no queuing.
REQ-013 turno SHALL be 0 in states 0-2, 1 in states 3-5, holding last mover in 6-7.
REQ-014 Counter SHALL be $clog2(TIMEOUT_CYCLES) bits, saturating never needed since cleared on leaving ESPERA.
REQ-015 All outputs SHALL be registered; jugada_invalida high exactly one cycle per rejection.

Reset
REQ-016 On rst=0 at clk edge: estado=ESPERA_J1, j1=0, j2=0, movimientos=0, counter=0, ganador=0, empate=0, jugada_invalida=0, turno=0.
REQ-017 Reset mid-game SHALL discard pending move; no partial board update.

Structure
REQ-018 State enum, line masks (8 x 9-bit), cell count 9 SHALL live in shared package ttt_pkg.
REQ-019 One combinational sub-module linea_ganadora (9-bit board in, 1-bit win out) SHALL be instantiated twice, once per player.

Verification
REQ-020 Reset, J1 D pos=4 -> estado 0,1,2,3; j1=9'h010; movimientos=1; turno=1.
REQ-021 J2 plays pos=4 after J1 took 4 -> jugada_invalida one-cycle pulse, estado back to 3, j2=0; pos=12 -> same rejection.
REQ-022 J1 cells 0,1,2 interleaved with J2 3,4 -> FIN_GANA, ganador=1, j1=9'h007; further D ignored.
REQ-023 Full sequence 0,1,2,4,3,5,7,6,8 -> FIN_EMPATE, empate=1, movimientos=9, ganador=0.
REQ-024 TIMEOUT_CYCLES=20, board j1=9'h001, J2 idle -> after 20 cycles j2=9'h002; D on cycle 19 with pos=8 -> j2=9'h100.
REQ-025 nuevo asserted in VALIDA_J2 with D -> next cycle estado=0, boards cleared; rst=0 mid-game -> all REQ-016 values.
